// File: rtl/ahb_triangle_unpacker_pkg.sv
// Shared geometry types and control-word constants for the host->GPU triangle stream.
// Also used by testbenches and the host-side driver model.
package ahb_triangle_unpacker_pkg;

    localparam logic [31:0] FRAME_START = 32'd0;
    localparam logic [31:0] FRAME_END   = 32'd1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FRAME   = 2'd1;
    localparam logic [1:0] ST_COLLECT = 2'd2;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

endpackage

// File: rtl/ahb_triangle_unpacker_slot.sv
// One-entry triangle output register with tri_ready/tri_read handshake.
// Load wins over a same-cycle read, so back-to-back triangles never bubble.
module tri_output_slot
    import ahb_triangle_unpacker_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  Triangle3D tri_i,
    input  Color      color_i,
    input  logic      tri_read_i,
    output Triangle3D tri_o,
    output Color      color_o,
    output logic      tri_ready_o
);

    Triangle3D tri_q;
    Color      color_q;
    logic      ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q   <= '0;
            color_q <= '0;
            ready_q <= 1'b0;
        end else if (load_i) begin
            tri_q   <= tri_i;
            color_q <= color_i;
            ready_q <= 1'b1;
        end else if (ready_q && tri_read_i) begin
            ready_q <= 1'b0;
        end
    end

    assign tri_o       = tri_q;
    assign color_o     = color_q;
    assign tri_ready_o = ready_q;

endmodule

// File: rtl/ahb_triangle_unpacker.sv
// Frames the AHB word stream and reassembles 6-word packets into triangle + colour.
// Triangle valid 1 cycle after the final word; final word and FRAME_END stall while the output slot is full.
module ahb_triangle_unpacker
    import ahb_triangle_unpacker_pkg::*;
#(
    parameter logic [31:0] FRAME_START_WORD = FRAME_START,
    parameter logic [31:0] FRAME_END_WORD   = FRAME_END,
    parameter int          DROP_CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ahb_buffer,
    input  logic                  ahb_data_available,
    output logic                  ahb_user_read_buffer,
    output Triangle3D             triangle,
    output Color                  color,
    output logic                  tri_ready,
    input  logic                  tri_read,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic [1:0]            state_q, state_d;
    logic [2:0]            word_idx_q, word_idx_d;
    logic [4:0][31:0]      asm_q, asm_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  active_q, active_d;
    logic                  done_q, done_d;

    logic      slot_free, is_start, is_end;
    logic      can_accept, accept, drop_inc, load;
    Triangle3D tri_new;
    Color      color_new;

    assign slot_free = !tri_ready || tri_read;
    assign is_start  = (ahb_buffer == FRAME_START_WORD);
    assign is_end    = (ahb_buffer == FRAME_END_WORD);

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        asm_d      = asm_q;
        drop_d     = drop_q;
        active_d   = active_q;
        done_d     = 1'b0;
        drop_inc   = 1'b0;
        load       = 1'b0;

        // Only the packet-closing word and FRAME_END depend on the output slot.
        can_accept = 1'b1;
        if (state_q == ST_FRAME && is_end)
            can_accept = slot_free;
        if (state_q == ST_COLLECT && word_idx_q == 3'd5)
            can_accept = slot_free;
        accept = ahb_data_available && can_accept && !rst;

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_start) begin
                        state_d  = ST_FRAME;
                        active_d = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (is_start) begin
                        drop_inc = 1'b1;
                    end else if (is_end) begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        asm_d[0]   = ahb_buffer;
                        word_idx_d = 3'd1;
                        state_d    = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (word_idx_q == 3'd5) begin
                        load       = 1'b1;
                        word_idx_d = 3'd0;
                        state_d    = ST_FRAME;
                    end else begin
                        asm_d[word_idx_q] = ahb_buffer;
                        word_idx_d        = word_idx_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (drop_inc && drop_q != {DROP_CNT_W{1'b1}})
            drop_d = drop_q + 1'b1;
    end

    always_comb begin
        tri_new.p.x = asm_q[0][15:0];
        tri_new.p.y = asm_q[0][31:16];
        tri_new.p.z = asm_q[1][15:0];
        tri_new.q.x = asm_q[1][31:16];
        tri_new.q.y = asm_q[2][15:0];
        tri_new.q.z = asm_q[2][31:16];
        tri_new.r.x = asm_q[3][15:0];
        tri_new.r.y = asm_q[3][31:16];
        tri_new.r.z = asm_q[4][15:0];
        color_new.r = asm_q[4][23:16];
        color_new.g = asm_q[4][31:24];
        color_new.b = ahb_buffer[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_idx_q <= 3'd0;
            asm_q      <= '0;
            drop_q     <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            asm_q      <= asm_d;
            drop_q     <= drop_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    tri_output_slot u_slot (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .tri_i       (tri_new),
        .color_i     (color_new),
        .tri_read_i  (tri_read),
        .tri_o       (triangle),
        .color_o     (color),
        .tri_ready_o (tri_ready)
    );

    assign ahb_user_read_buffer = accept;
    assign frame_active         = active_q;
    assign frame_done           = done_q;
    assign drop_count           = drop_q;

endmodule

// File: tb/tb_ahb_triangle_unpacker.sv
// Directed and randomized stimulus checked every cycle against a queue-based packet model.
module tb_ahb_triangle_unpacker;
    import ahb_triangle_unpacker_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ahb_buffer = '0;
    logic        ahb_data_available = 1'b0;
    logic        ahb_user_read_buffer;
    Triangle3D   triangle;
    Color        color;
    logic        tri_ready;
    logic        tri_read = 1'b0;
    logic        frame_active;
    logic        frame_done;
    logic [7:0]  drop_count;

    ahb_triangle_unpacker dut (
        .clk                  (clk),
        .rst                  (rst),
        .ahb_buffer           (ahb_buffer),
        .ahb_data_available   (ahb_data_available),
        .ahb_user_read_buffer (ahb_user_read_buffer),
        .triangle             (triangle),
        .color                (color),
        .tri_ready            (tri_ready),
        .tri_read             (tri_read),
        .frame_active         (frame_active),
        .frame_done           (frame_done),
        .drop_count           (drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: 0 = outside frame, 1 = frame between packets, 2 = collecting a packet.
    int          m_mode = 0;
    logic [31:0] m_words[$];
    logic        m_ready = 1'b0;
    Triangle3D   m_tri = '0;
    Color        m_col = '0;
    logic        m_active = 1'b0;
    logic        m_done = 1'b0;
    int          m_drop = 0;
    logic        last_rb;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_accept();
        logic slot_free;
        slot_free = !m_ready || tri_read;
        if (rst || !ahb_data_available) return 1'b0;
        if (m_mode == 1 && ahb_buffer == FRAME_END) return slot_free;
        if (m_mode == 2 && m_words.size() == 5) return slot_free;
        return 1'b1;
    endfunction

    function automatic void m_decode();
        m_tri.p.x = m_words[0][15:0];   m_tri.p.y = m_words[0][31:16];
        m_tri.p.z = m_words[1][15:0];   m_tri.q.x = m_words[1][31:16];
        m_tri.q.y = m_words[2][15:0];   m_tri.q.z = m_words[2][31:16];
        m_tri.r.x = m_words[3][15:0];   m_tri.r.y = m_words[3][31:16];
        m_tri.r.z = m_words[4][15:0];
        m_col.r   = m_words[4][23:16];
        m_col.g   = m_words[4][31:24];
        m_col.b   = m_words[5][7:0];
    endfunction

    task automatic m_update(input logic r, input logic acc, input logic [31:0] w, input logic rd);
        logic loaded;
        loaded = 1'b0;
        if (r) begin
            m_mode = 0; m_words.delete(); m_ready = 0; m_tri = '0; m_col = '0;
            m_active = 0; m_done = 0; m_drop = 0;
            return;
        end
        m_done = 1'b0;
        if (acc) begin
            if (m_mode == 0) begin
                if (w == FRAME_START) begin m_mode = 1; m_active = 1; end
                else if (m_drop < 255) m_drop++;
            end else if (m_mode == 1) begin
                if (w == FRAME_START) begin
                    if (m_drop < 255) m_drop++;
                end else if (w == FRAME_END) begin
                    m_mode = 0; m_active = 0; m_done = 1;
                end else begin
                    m_words.push_back(w); m_mode = 2;
                end
            end else begin
                m_words.push_back(w);
                if (m_words.size() == 6) begin
                    m_decode(); loaded = 1'b1; m_words.delete(); m_mode = 1;
                end
            end
        end
        if (loaded) m_ready = 1'b1;
        else if (m_ready && rd) m_ready = 1'b0;
    endtask

    task automatic step(input logic r, input logic av, input logic [31:0] w, input logic rd);
        logic acc;
        @(negedge clk);
        rst = r; ahb_data_available = av; ahb_buffer = w; tri_read = rd;
        #1;
        acc = m_accept();
        last_rb = ahb_user_read_buffer;
        chk("read_buffer", ahb_user_read_buffer, acc);
        chk("tri_ready", tri_ready, m_ready);
        chk("triangle", triangle, m_tri);
        chk("color", color, m_col);
        chk("frame_active", frame_active, m_active);
        chk("frame_done", frame_done, m_done);
        chk("drop_count", drop_count, m_drop[7:0]);
        @(posedge clk);
        m_update(r, acc, w, rd);
    endtask

    logic [31:0] pkt1 [6] = '{32'h00200010, 32'h00400030, 32'h00600050,
                              32'h00800070, 32'h00FF0090, 32'h00000080};
    logic [31:0] pkt2 [6] = '{32'h02020101, 32'h04040303, 32'h06060505,
                              32'h08080707, 32'h0A0B0909, 32'h0000000C};
    Triangle3D lit_t;
    Color      lit_c;

    initial begin
        lit_t.p = '{16'h10, 16'h20, 16'h30};
        lit_t.q = '{16'h40, 16'h50, 16'h60};
        lit_t.r = '{16'h70, 16'h80, 16'h90};
        lit_c   = '{8'hFF, 8'h00, 8'h80};

        repeat (2) @(posedge clk);
        step(1, 1, 32'h0, 0);
        chk("rb_in_reset", last_rb, 1'b0);
        step(0, 0, 32'h0, 0);
        chk("reset_tri_ready", tri_ready, 1'b0);
        chk("reset_drop", drop_count, 8'd0);
        chk("reset_active", frame_active, 1'b0);
        chk("reset_triangle", triangle, '0);

        // First packet: all seven words accepted, triangle valid one cycle later.
        step(0, 1, FRAME_START, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, pkt1[i], 0);
            chk("pkt1_rb", last_rb, 1'b1);
        end
        #2;
        chk("pkt1_ready", tri_ready, 1'b1);
        chk("pkt1_tri", triangle, lit_t);
        chk("pkt1_color", color, lit_c);

        // Second packet collects behind the held triangle; w5 waits for tri_read.
        for (int i = 0; i < 5; i++) step(0, 1, pkt2[i], 0);
        step(0, 1, pkt2[5], 0);
        chk("w5_stall", last_rb, 1'b0);
        step(0, 1, pkt2[5], 0);
        chk("w5_stall2", last_rb, 1'b0);
        step(0, 1, pkt2[5], 1);
        chk("w5_accept", last_rb, 1'b1);
        #2;
        chk("pkt2_ready", tri_ready, 1'b1);
        chk("pkt2_px", triangle.p.x, 16'h0101);
        chk("pkt2_color", color, 24'h0B0A0C);
        step(0, 0, 32'h0, 1);
        step(0, 1, FRAME_END, 0);
        #2;
        chk("end_done", frame_done, 1'b1);

        // Junk outside a frame is dropped.
        step(0, 1, 32'h1234, 0);
        step(0, 1, FRAME_END, 0);
        step(0, 1, 32'd5, 0);
        #2;
        chk("idle_drop3", drop_count, 8'd3);
        chk("idle_inactive", frame_active, 1'b0);
        step(0, 1, FRAME_START, 0);
        #2;
        chk("start_active", frame_active, 1'b1);

        // FRAME_END stalls behind an unread triangle.
        for (int i = 0; i < 6; i++) step(0, 1, pkt1[i], 0);
        step(0, 1, FRAME_END, 0);
        chk("end_stall", last_rb, 1'b0);
        step(0, 1, FRAME_END, 1);
        chk("end_accept", last_rb, 1'b1);
        #2;
        chk("end_done_pulse", frame_done, 1'b1);
        chk("end_inactive", frame_active, 1'b0);
        step(0, 0, 32'h0, 0);
        #2;
        chk("end_done_clear", frame_done, 1'b0);

        for (int i = 0; i < 300; i++) step(0, 1, 32'h1000 + i, 0);
        #2;
        chk("drop_saturate", drop_count, 8'hFF);

        // Reset mid-packet, then a clean packet must decode without stale words.
        step(0, 1, FRAME_START, 0);
        for (int i = 0; i < 4; i++) step(0, 1, pkt2[i], 0);
        step(1, 1, pkt2[4], 0);
        #2;
        chk("midrst_drop", drop_count, 8'd0);
        chk("midrst_ready", tri_ready, 1'b0);
        chk("midrst_active", frame_active, 1'b0);
        chk("midrst_tri", triangle, '0);
        step(0, 1, FRAME_START, 0);
        for (int i = 0; i < 6; i++) step(0, 1, pkt1[i], 0);
        #2;
        chk("post_rst_tri", triangle, lit_t);
        chk("post_rst_color", color, lit_c);

        // Randomized traffic with gaps, control words, backpressure and rare resets.
        for (int i = 0; i < 4000; i++) begin
            logic        r, av, rd;
            logic [31:0] w;
            int          sel;
            r   = ($urandom_range(0, 299) == 0);
            av  = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 19);
            w   = (sel == 0) ? FRAME_START : (sel == 1) ? FRAME_END : $urandom;
            rd  = $urandom_range(0, 1) == 1;
            step(r, av, w, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
